// File: rtl/waveform_analyzer.sv
// Waveform analyzer: adaptive-midpoint crossing detector with hysteresis.
// Measures period, extremes, peak-to-peak and high time of each full cycle.
module waveform_analyzer #(
    parameter int                DATA_W = 8,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] HYST   = 8'd16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vpp,
    output logic [CNT_W-1:0]  high_cnt,
    output logic              meas_valid,
    output logic              no_signal
);

    typedef enum logic {
        SEEK,
        MEASURE
    } state_t;

    localparam logic [DATA_W-1:0] MID_RST = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONE = {DATA_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic [DATA_W-1:0]   mid;
    logic                above;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   run_max;
    logic [DATA_W-1:0]   run_min;
    logic [CNT_W-1:0]    run_high;

    logic [DATA_W:0]     hi_sum;
    logic [DATA_W:0]     lo_dif;
    logic [DATA_W:0]     mid_sum;
    logic [DATA_W-1:0]   th_hi;
    logic [DATA_W-1:0]   th_lo;
    logic [DATA_W-1:0]   mid_new;
    logic [DATA_W-1:0]   win_max;
    logic [DATA_W-1:0]   win_min;
    logic                above_nx;
    logic                rise;
    logic                cnt_full;

    // Hysteresis thresholds, saturated at the rails
    assign hi_sum  = {1'b0, mid} + {1'b0, HYST};
    assign lo_dif  = {1'b0, mid} - {1'b0, HYST};
    assign th_hi   = hi_sum[DATA_W] ? ALL_ONE : hi_sum[DATA_W-1:0];
    assign th_lo   = lo_dif[DATA_W] ? '0 : lo_dif[DATA_W-1:0];

    // Next midpoint is the centre of the window being closed
    assign mid_sum = {1'b0, run_max} + {1'b0, run_min};
    assign mid_new = DATA_W'(mid_sum >> 1);

    // Window extremes including the current sample
    assign win_max = (adc_data > run_max) ? adc_data : run_max;
    assign win_min = (adc_data < run_min) ? adc_data : run_min;

    assign cnt_full = (cnt == CNT_MAX);

    // Level flag update: set wins at or above th_hi, clear at or below th_lo
    always_comb begin
        above_nx = above;
        if (adc_data >= th_hi) begin
            above_nx = 1'b1;
        end else if (adc_data <= th_lo) begin
            above_nx = 1'b0;
        end
    end

    assign rise = ~above & above_nx;

    // Cycle measurement FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SEEK;
            mid        <= MID_RST;
            above      <= 1'b0;
            cnt        <= '0;
            run_max    <= '0;
            run_min    <= '0;
            run_high   <= '0;
            period     <= '0;
            vmax       <= '0;
            vmin       <= '0;
            vpp        <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
            if (adc_valid) begin
                above <= above_nx;
                unique case (state)
                    SEEK: begin
                        if (rise) begin
                            state    <= MEASURE;
                            cnt      <= CNT_ONE;
                            run_max  <= adc_data;
                            run_min  <= adc_data;
                            run_high <= CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period     <= cnt;
                            vmax       <= run_max;
                            vmin       <= run_min;
                            vpp        <= run_max - run_min;
                            high_cnt   <= run_high;
                            meas_valid <= 1'b1;
                            no_signal  <= 1'b0;
                            mid        <= mid_new;
                            cnt        <= CNT_ONE;
                            run_max    <= adc_data;
                            run_min    <= adc_data;
                            run_high   <= CNT_ONE;
                        end else if (cnt_full) begin
                            state     <= SEEK;
                            no_signal <= 1'b1;
                            mid       <= MID_RST;
                        end else begin
                            cnt      <= cnt + CNT_ONE;
                            run_max  <= win_max;
                            run_min  <= win_min;
                            run_high <= run_high + CNT_W'(above_nx);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_waveform_analyzer.sv
// Directed testbench for waveform_analyzer.
// Each task drives one scenario and checks hand-computed results inline.
`timescale 1ns/1ps
module tb_waveform_analyzer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic [15:0] period;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
    logic [7:0]  vpp;
    logic [15:0] high_cnt;
    logic        meas_valid;
    logic        no_signal;

    int vecs;
    int errs;
    int cyc;
    int pulses;
    int t_last;
    int t_prev;

    waveform_analyzer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .period     (period),
        .vmax       (vmax),
        .vmin       (vmin),
        .vpp        (vpp),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .no_signal  (no_signal)
    );

    // 10 MHz clock
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Drive one clock from a negedge, sample results on the next negedge
    task automatic push(input logic [7:0] d, input logic v);
        adc_data  = d;
        adc_valid = v;
        @(negedge clk);
        cyc++;
        if (meas_valid === 1'b1) begin
            pulses++;
            t_prev = t_last;
            t_last = cyc;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        push(8'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] sq(input int k);
        return ((k % 16) < 8) ? 8'd255 : 8'd0;
    endfunction

    task automatic square(input int n);
        for (int k = 0; k < n; k++) push(sq(k), 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (period !== 16'd0 || vmax !== 8'd0 || vmin !== 8'd0 ||
            vpp !== 8'd0 || high_cnt !== 16'd0) begin
            errs++;
            $display("FAIL reset_outs got %0d/%0d/%0d/%0d/%0d want 0/0/0/0/0",
                     period, vmax, vmin, vpp, high_cnt);
        end
        vecs++;
        if (meas_valid !== 1'b0 || no_signal !== 1'b1) begin
            errs++;
            $display("FAIL reset_flags got mv=%b ns=%b want mv=0 ns=1",
                     meas_valid, no_signal);
        end
        vecs++;
        if (dut.mid !== 8'd128 || dut.above !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid got mid=%0d above=%b want 128/0",
                     dut.mid, dut.above);
        end
    endtask

    task automatic test_square();
        int p0;
        do_reset();
        p0 = pulses;
        square(16);
        vecs++;
        if (pulses !== p0) begin
            errs++;
            $display("FAIL sq_early got %0d pulses want 0", pulses - p0);
        end
        push(8'd255, 1'b1);
        vecs++;
        if (meas_valid !== 1'b1) begin
            errs++;
            $display("FAIL sq_pulse17 got %b want 1", meas_valid);
        end
        vecs++;
        if (period !== 16'd16 || vmax !== 8'd255 || vmin !== 8'd0 ||
            vpp !== 8'd255 || high_cnt !== 16'd8 || no_signal !== 1'b0) begin
            errs++;
            $display("FAIL sq_meas got %0d/%0d/%0d/%0d/%0d ns=%b want 16/255/0/255/8 ns=0",
                     period, vmax, vmin, vpp, high_cnt, no_signal);
        end
        vecs++;
        if (dut.mid !== 8'd127) begin
            errs++;
            $display("FAIL sq_mid got %0d want 127", dut.mid);
        end
        push(8'd255, 1'b1);
        vecs++;
        if (meas_valid !== 1'b0 || period !== 16'd16) begin
            errs++;
            $display("FAIL sq_one_cycle got mv=%b period=%0d want mv=0 period=16",
                     meas_valid, period);
        end
        for (int k = 2; k < 17; k++) push(sq(k), 1'b1);
        vecs++;
        if (pulses - p0 !== 2 || period !== 16'd16 || high_cnt !== 16'd8) begin
            errs++;
            $display("FAIL sq_second got pulses=%0d period=%0d high=%0d want 2/16/8",
                     pulses - p0, period, high_cnt);
        end
    endtask

    task automatic test_sawtooth();
        int p0;
        int bad;
        do_reset();
        p0  = pulses;
        bad = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                push(8'(i * 16), 1'b1);
                if (meas_valid === 1'b1) begin
                    if (period !== 16'd16 || vmax !== 8'd240 || vmin !== 8'd0 ||
                        vpp !== 8'd240 || high_cnt !== 16'd7) bad++;
                end
            end
        end
        vecs++;
        if (pulses - p0 !== 3) begin
            errs++;
            $display("FAIL saw_pulses got %0d want 3", pulses - p0);
        end
        vecs++;
        if (bad !== 0) begin
            errs++;
            $display("FAIL saw_meas got %0d bad pulses, last %0d/%0d/%0d/%0d/%0d want 16/240/0/240/7",
                     bad, period, vmax, vmin, vpp, high_cnt);
        end
        vecs++;
        if (dut.mid !== 8'd120) begin
            errs++;
            $display("FAIL saw_mid got %0d want 120", dut.mid);
        end
    endtask

    task automatic test_gapped();
        int p0;
        int bad_mv;
        do_reset();
        p0     = pulses;
        bad_mv = 0;
        for (int k = 0; k < 33; k++) begin
            push(sq(k), 1'b1);
            push(8'h55, 1'b0);
            if (meas_valid !== 1'b0) bad_mv++;
        end
        vecs++;
        if (pulses - p0 !== 2 || t_last - t_prev !== 32) begin
            errs++;
            $display("FAIL gap_spacing got pulses=%0d spacing=%0d want 2/32",
                     pulses - p0, t_last - t_prev);
        end
        vecs++;
        if (period !== 16'd16 || vmax !== 8'd255 || vmin !== 8'd0 ||
            vpp !== 8'd255 || high_cnt !== 16'd8) begin
            errs++;
            $display("FAIL gap_meas got %0d/%0d/%0d/%0d/%0d want 16/255/0/255/8",
                     period, vmax, vmin, vpp, high_cnt);
        end
        vecs++;
        if (bad_mv !== 0) begin
            errs++;
            $display("FAIL gap_idle_mv got %0d pulses on idle cycles want 0", bad_mv);
        end
    endtask

    task automatic test_timeout();
        int p0;
        do_reset();
        square(17);
        p0 = pulses;
        for (int k = 0; k < 65534; k++) push(8'd200, 1'b1);
        vecs++;
        if (no_signal !== 1'b0) begin
            errs++;
            $display("FAIL to_early got ns=%b want 0", no_signal);
        end
        push(8'd200, 1'b1);
        vecs++;
        if (no_signal !== 1'b1 || dut.mid !== 8'd128) begin
            errs++;
            $display("FAIL to_fire got ns=%b mid=%0d want 1/128", no_signal, dut.mid);
        end
        vecs++;
        if (pulses !== p0 || period !== 16'd16 || vmax !== 8'd255 ||
            vmin !== 8'd0 || vpp !== 8'd255 || high_cnt !== 16'd8) begin
            errs++;
            $display("FAIL to_hold got pulses=%0d %0d/%0d/%0d/%0d/%0d want 0 16/255/0/255/8",
                     pulses - p0, period, vmax, vmin, vpp, high_cnt);
        end
        square(16);
        square(17);
        vecs++;
        if (meas_valid !== 1'b1 || pulses - p0 !== 1 || no_signal !== 1'b0 ||
            period !== 16'd16) begin
            errs++;
            $display("FAIL to_resume got mv=%b pulses=%0d ns=%b period=%0d want 1/1/0/16",
                     meas_valid, pulses - p0, no_signal, period);
        end
    endtask

    task automatic test_noise();
        int p0;
        do_reset();
        p0 = pulses;
        push(8'd255, 1'b1);
        for (int k = 0; k < 3; k++) begin
            push(8'd140, 1'b1);
            push(8'd120, 1'b1);
        end
        push(8'd113, 1'b1);
        vecs++;
        if (dut.above !== 1'b1 || pulses !== p0) begin
            errs++;
            $display("FAIL noise_hold got above=%b pulses=%0d want 1/0",
                     dut.above, pulses - p0);
        end
        push(8'd112, 1'b1);
        push(8'd143, 1'b1);
        vecs++;
        if (dut.above !== 1'b0 || pulses !== p0) begin
            errs++;
            $display("FAIL noise_low got above=%b pulses=%0d want 0/0",
                     dut.above, pulses - p0);
        end
        push(8'd144, 1'b1);
        vecs++;
        if (meas_valid !== 1'b1 || period !== 16'd10 || vmax !== 8'd255 ||
            vmin !== 8'd112 || vpp !== 8'd143 || high_cnt !== 16'd8) begin
            errs++;
            $display("FAIL noise_cross got mv=%b %0d/%0d/%0d/%0d/%0d want 1 10/255/112/143/8",
                     meas_valid, period, vmax, vmin, vpp, high_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int p0;
        do_reset();
        square(20);
        rst_n = 1'b0;
        push(8'd255, 1'b1);
        rst_n = 1'b1;
        vecs++;
        if (period !== 16'd0 || vmax !== 8'd0 || vmin !== 8'd0 || vpp !== 8'd0 ||
            high_cnt !== 16'd0 || meas_valid !== 1'b0 || no_signal !== 1'b1) begin
            errs++;
            $display("FAIL mrst_outs got %0d/%0d/%0d/%0d/%0d mv=%b ns=%b want zeros mv=0 ns=1",
                     period, vmax, vmin, vpp, high_cnt, meas_valid, no_signal);
        end
        p0 = pulses;
        square(16);
        vecs++;
        if (pulses !== p0) begin
            errs++;
            $display("FAIL mrst_early got %0d pulses want 0", pulses - p0);
        end
        push(8'd255, 1'b1);
        vecs++;
        if (meas_valid !== 1'b1 || period !== 16'd16 || high_cnt !== 16'd8) begin
            errs++;
            $display("FAIL mrst_second got mv=%b period=%0d high=%0d want 1/16/8",
                     meas_valid, period, high_cnt);
        end
    endtask

    initial begin
        vecs      = 0;
        errs      = 0;
        cyc       = 0;
        pulses    = 0;
        t_last    = 0;
        t_prev    = 0;
        rst_n     = 1'b0;
        adc_data  = 8'd0;
        adc_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_square();
        test_sawtooth();
        test_gapped();
        test_noise();
        test_mid_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/waveform_analyzer.md
# waveform_analyzer

Capture-side counterpart to the DDS waveform generator. The block accepts the 8-bit sample stream from the ADC front end, detects rising crossings of an adaptive midpoint with hysteresis, and measures each full cycle. Per-cycle outputs are:
- period in samples
- maximum, minimum and peak-to-peak amplitude
- samples-above-midpoint count, used for duty-cycle display

It sits between the ADC interface and the seven-segment/status logic. In loopback tests it checks the generator's output against its frequency word.

## Interface
Parameters:
- `DATA_W`, 8: sample width.
- `CNT_W`, 16: period and high-count width.
- `HYST`, 8'd16: hysteresis half-band around the midpoint.

Ports:
- `clk`, input, 1: system clock (10 MHz).
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `adc_data`, input, DATA_W: ADC sample, unsigned.
- `adc_valid`, input, 1: `adc_data` is valid this cycle.
- `period`, output, CNT_W: samples per cycle of the last measured cycle.
- `vmax`, output, DATA_W: maximum sample of the last cycle.
- `vmin`, output, DATA_W: minimum sample of the last cycle.
- `vpp`, output, DATA_W: `vmax - vmin`.
- `high_cnt`, output, CNT_W: samples in the last cycle with the level flag set.
- `meas_valid`, output, 1: one-cycle pulse when all measurement outputs update.
- `no_signal`, output, 1: no cycle measured since reset or since the last timeout.

## Operation
- Only cycles with `adc_valid=1` advance any state. With `adc_valid=0`, all registers hold and `meas_valid` is 0.
- Midpoint register `mid` (DATA_W):
  - Reset value 128.
  - Thresholds are `th_hi = min(mid+HYST, 255)` and `th_lo = max(mid-HYST, 0)`. Compute both at DATA_W+1 bits, then saturate.
- Level flag `above`:
  - Set when sample >= `th_hi`.
  - Cleared when sample <= `th_lo`.
  - Otherwise holds.
  - Reset value 0.
- Rising crossing: a valid sample that sets `above` while it was 0.
- Running window registers: `cnt`, `run_max`, `run_min`, `run_high`.
- FSM states:
  - SEEK (reset state): track `above` only. On a rising crossing, go to MEASURE and set `cnt=1`, `run_max=run_min=sample`, `run_high=1`.
  - MEASURE, each valid sample without a crossing:
    - `cnt+1`.
    - `run_max`/`run_min` update with the sample.
    - `run_high+1` if `above` is 1 after this sample's update.
  - MEASURE, rising crossing (closes the cycle):
    - Latch `period=cnt`, `vmax=run_max`, `vmin=run_min`, `vpp=run_max-run_min`, `high_cnt=run_high`.
    - Pulse `meas_valid` and clear `no_signal`.
    - Set `mid = (run_max + run_min) >> 1`, computed at DATA_W+1 bits.
    - Restart the window with the crossing sample: `cnt=1`, `run_max=run_min=sample`, `run_high=1`.
    - Stay in MEASURE.
  - MEASURE timeout: a valid sample arrives with `cnt = 2^CNT_W-1` and no crossing.
    - Go to SEEK, set `no_signal=1`, set `mid=128`.
    - No `meas_valid` pulse; measurement outputs keep their last values.
- The crossing sample belongs to the new cycle, not the closed one.
- The new `mid` takes effect from the next valid sample.

## Timing
- Reset values (one edge with `rst_n=0`): `period=0`, `vmax=0`, `vmin=0`, `vpp=0`, `high_cnt=0`, `meas_valid=0`, `no_signal=1`, `mid=128`, `above=0`, state SEEK.
- Reset asserted mid-cycle discards the partial window. No `meas_valid` pulse is produced.
- Latency: outputs and `meas_valid` are registered. They change on the clock edge that samples the crossing, so they are visible the following cycle.
- `meas_valid` is high for exactly one cycle per closed cycle.
- Consecutive pulses are at least 2 valid samples apart, because `period >= 2` with hysteresis.
- The first rising crossing after reset or timeout produces no output. The first `meas_valid` comes at the second crossing.
- `cnt` never wraps. The timeout precedes overflow.
- A constant input never crosses: timeout occurs after 65535 valid samples in MEASURE; in SEEK, no output.

## Test plan
1. Reset, then square wave of 8×255 followed by 8×0, repeated, all valid. Required response:
   - First `meas_valid` one cycle after the 17th sample (second crossing).
   - `period=16`, `vmax=255`, `vmin=0`, `vpp=255`, `high_cnt=8`, `no_signal=0`.
2. Sawtooth 0,16,…,240, repeated. Required response:
   - Each pulse reports `period=16`, `vmax=240`, `vmin=0`, `vpp=240`, `high_cnt=7`.
   - `mid` becomes 120 after the first measurement.
3. Run the square wave of test 1 with `adc_valid` toggling 1,0,1,0. Required response: identical measurements to test 1. Pulses are spaced 32 clocks apart.
4. After lock on the square wave, hold the input at 200 for 65535 valid samples. Required response:
   - `no_signal=1`, no extra `meas_valid`, outputs unchanged, `mid` back to 128.
   - Resuming the square wave gives a new pulse at the second crossing.
5. Noise at threshold: with `mid=128`, feed samples alternating 140/120 after a crossing. Required response: no new crossing and `above` stays 1. Only a sample <=112 followed by one >=144 crosses.
6. Assert `rst_n=0` for one cycle mid-period during test 1. Required response:
   - All outputs return to reset values.
   - Next `meas_valid` appears only after two new crossings.
